ram_atob_packer: RTL

Fast-domain reader that fetches MULTNUM consecutive narrow words (DWA) from the port-A RAM, packs them into one wide DWB word, and delivers it to the slow clk_b domain. Entry is an 8-entry gray-pointer async FIFO. It is the A→B counterpart of the dual-port RAM's B→A write path: requests arrive in the fastclk_a domain, and packed data leaves on a valid/ready interface in clk_b.

---
 rtl/ram_atob_packer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ram_atob_packer.sv
// Packs MULTNUM narrow port-A RAM words into one wide word and hands it to clk_b
// through an 8-entry gray-pointer FIFO. Define ATOB_LANE_LSB_FIRST_EN to place lane 0 at the LSB.
module ram_atob_packer #(
  parameter int DWA     = 16,
  parameter int AWA     = 6,
  parameter int MULTNUM = 4,
  parameter int DWB     = DWA * MULTNUM,
  parameter int AWB     = AWA - $clog2(MULTNUM)
) (
  input  logic           fastclk_a,
  input  logic           rst_a,
  input  logic           clk_b,
  input  logic           rst_b,
  input  logic           i_req_valid,
  input  logic [AWB-1:0] i_req_addr,
  output logic           o_req_ready,
  output logic           o_ram_rd_en,
  output logic [AWA-1:0] o_ram_addr,
  input  logic [DWA-1:0] i_ram_data,
  output logic           o_valid_b,
  output logic [DWB-1:0] o_data_b,
  input  logic           i_ready_b
);

  localparam int LANE_BITS = $clog2(MULTNUM);
  localparam int LW        = (LANE_BITS > 0) ? LANE_BITS : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WAIT, ST_PUSH} state_t;

  function automatic logic [3:0] bin2gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int lane_lo(input int k);
`ifdef ATOB_LANE_LSB_FIRST_EN
    return k * DWA;
`else
    return DWB - (k + 1) * DWA;
`endif
  endfunction

  // ---------------- fastclk_a domain ----------------
  state_t          state_q, state_d;
  logic [AWB-1:0]  addr_q, addr_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic            cap_en_q, cap_en_d;
  logic [LW-1:0]   cap_lane_q, cap_lane_d;
  logic [DWB-1:0]  pack_q, pack_d;
  logic [3:0]      wptr_q, wptr_d;
  logic [3:0]      wgray_q, wgray_d;
  logic [3:0]      rgray_s1_q, rgray_s2_q;
  logic            full_a;
  logic            push;

  logic [DWB-1:0]  fifo_mem [8];

  // ---------------- clk_b domain ----------------
  logic [3:0]      rptr_q, rptr_d;
  logic [3:0]      rgray_q, rgray_d;
  logic [3:0]      wgray_s1_q, wgray_s2_q;
  logic            empty_b;
  logic            pop;

  assign full_a = (wgray_q == {~rgray_s2_q[3:2], rgray_s2_q[1:0]});

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    lane_d      = lane_q;
    o_req_ready = 1'b0;
    o_ram_rd_en = 1'b0;
    push        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_req_ready = !full_a;
        if (i_req_valid && !full_a) begin
          addr_d  = i_req_addr;
          lane_d  = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        o_ram_rd_en = 1'b1;
        if (lane_q == LW'(MULTNUM - 1)) begin
          state_d = ST_WAIT;
        end else begin
          lane_d = lane_q + LW'(1);
        end
      end
      ST_WAIT: begin
        state_d = ST_PUSH;
      end
      ST_PUSH: begin
        push    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  generate
    if (LANE_BITS == 0) begin : g_addr_single
      assign o_ram_addr = addr_q;
    end else begin : g_addr_lanes
      assign o_ram_addr = {addr_q, lane_q[LANE_BITS-1:0]};
    end
  endgenerate

  // RAM data returns one cycle after the strobe, so the lane tag is delayed with it.
  always_comb begin
    cap_en_d   = o_ram_rd_en;
    cap_lane_d = lane_q;
    pack_d     = pack_q;
    if (cap_en_q) begin
      for (int k = 0; k < MULTNUM; k++) begin
        if (cap_lane_q == LW'(k)) begin
          pack_d[lane_lo(k) +: DWA] = i_ram_data;
        end
      end
    end
    wptr_d  = wptr_q + 4'(push);
    wgray_d = bin2gray(wptr_d);
  end

  always_ff @(posedge fastclk_a or posedge rst_a) begin
    if (rst_a) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      lane_q     <= '0;
      cap_en_q   <= 1'b0;
      cap_lane_q <= '0;
      pack_q     <= '0;
      wptr_q     <= '0;
      wgray_q    <= '0;
      rgray_s1_q <= '0;
      rgray_s2_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      lane_q     <= lane_d;
      cap_en_q   <= cap_en_d;
      cap_lane_q <= cap_lane_d;
      pack_q     <= pack_d;
      wptr_q     <= wptr_d;
      wgray_q    <= wgray_d;
      rgray_s1_q <= rgray_q;
      rgray_s2_q <= rgray_s1_q;
    end
  end

  // Storage is deliberately unreset; the pointers alone define occupancy.
  always_ff @(posedge fastclk_a) begin
    if (push) begin
      fifo_mem[wptr_q[2:0]] <= pack_q;
    end
  end

  assign empty_b   = (rgray_q == wgray_s2_q);
  assign o_valid_b = !empty_b;
  assign pop       = o_valid_b && i_ready_b;
  assign o_data_b  = fifo_mem[rptr_q[2:0]];

  always_comb begin
    rptr_d  = rptr_q + 4'(pop);
    rgray_d = bin2gray(rptr_d);
  end

  always_ff @(posedge clk_b or posedge rst_b) begin
    if (rst_b) begin
      rptr_q     <= '0;
      rgray_q    <= '0;
      wgray_s1_q <= '0;
      wgray_s2_q <= '0;
    end else begin
      rptr_q     <= rptr_d;
      rgray_q    <= rgray_d;
      wgray_s1_q <= wgray_q;
      wgray_s2_q <= wgray_s1_q;
    end
  end

endmodule
